// File: rtl/ad7606_sched.sv
// ad7606_sched: AD7606 conversion scheduler with frame capture and show-ahead output FIFO.
// Define AD7606_SCHED_TIMEOUT_EN to add the WAIT-state watchdog (timeout_err).
module ad7606_sched #(
  parameter int CLK_FRE     = 50,
  parameter int SAMPLE_FRE  = 1000,
  parameter int FIFO_DEPTH  = 64,
  parameter int TIMEOUT_CYC = CLK_FRE * 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         single,
  input  logic [7:0]   ch_mask,
  output logic         adc_start,
  input  logic         adc_done,
  input  logic [127:0] adc_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic [2:0]   out_ch,
  output logic         out_sof,
  output logic         busy,
  output logic         overrun,
  input  logic         overrun_clr,
  output logic         timeout_err,
  output logic [15:0]  frame_cnt
);
  localparam int PERIOD = CLK_FRE * 1_000_000 / SAMPLE_FRE;
  localparam int TW = $clog2(PERIOD + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, TRIG = 2'd1, WAIT = 2'd2, UNLOAD = 2'd3} state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) c = 3'(i);
    return c;
  endfunction

  state_t          state_r, state_next_s;
  logic            run_d_r, done_d_r;
  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s, trig_s, done_rise_s, fit_s, last_s;
  logic [CW-1:0]   count_r, free_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [19:0]     mem_r [FIFO_DEPTH];
  logic [19:0]     head_s, entry_s;
  logic [127:0]    shadow_r;
  logic [7:0]      mask_r;
  logic            sof_r;
  logic [2:0]      cur_ch_s;
  logic            push_s, pop_s, wr_en_s, ovr_set_s, out_valid_s;
  logic            adc_start_r, busy_r, overrun_r;
  logic [15:0]     frame_cnt_r;
  logic            timeout_s;

  // Tick fires on the run rising edge and then every PERIOD cycles.
  always_comb begin
    tick_s      = run & ((run & ~run_d_r) | (tick_cnt_r == TW'(PERIOD)));
    trig_s      = tick_s | single;
    done_rise_s = adc_done & ~done_d_r;
    free_s      = CW'(FIFO_DEPTH) - count_r;
    fit_s       = (ch_mask != 8'd0) && (free_s >= CW'(popcount8(ch_mask)));
    cur_ch_s    = lowest_ch(mask_r);
    last_s      = ((mask_r & ~(8'd1 << cur_ch_s)) == 8'd0);
    entry_s     = {sof_r, cur_ch_s, shadow_r[{cur_ch_s, 4'd0} +: 16]};
  end

  // Tick counter and edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_d_r    <= 1'b0;
      done_d_r   <= 1'b0;
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      run_d_r  <= run;
      done_d_r <= adc_done;
      if (!run)        tick_cnt_r <= {TW{1'b0}};
      else if (tick_s) tick_cnt_r <= TW'(1);
      else             tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

`ifdef AD7606_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wait_cnt_r;
  logic          timeout_err_r;
  assign timeout_s   = (state_r == WAIT) && !done_rise_s && (wait_cnt_r == WW'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_err_r;
  // WAIT watchdog; restarts on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_r    <= {WW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r != WAIT) wait_cnt_r <= {WW{1'b0}};
      else                 wait_cnt_r <= wait_cnt_r + WW'(1);
      if (timeout_s) timeout_err_r <= 1'b1;
      else           timeout_err_r <= timeout_err_r;
    end
  end
`else
  assign timeout_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (trig_s) state_next_s = TRIG; else state_next_s = IDLE;
      TRIG:    state_next_s = WAIT;
      WAIT: begin
        if (done_rise_s)    state_next_s = fit_s ? UNLOAD : IDLE;
        else if (timeout_s) state_next_s = IDLE;
        else                state_next_s = WAIT;
      end
      UNLOAD:  if (last_s) state_next_s = IDLE; else state_next_s = UNLOAD;
      default: state_next_s = IDLE;
    endcase
  end

  // Output/datapath decode; a zero-mask drop is silent, a no-space drop is an overrun.
  always_comb begin
    out_valid_s = (count_r != {CW{1'b0}});
    push_s      = (state_r == UNLOAD);
    pop_s       = out_valid_s & out_ready;
    wr_en_s     = push_s && ((count_r != CW'(FIFO_DEPTH)) || pop_s);
    ovr_set_s   = (trig_s && (state_r != IDLE)) ||
                  ((state_r == WAIT) && done_rise_s && (ch_mask != 8'd0) && !fit_s);
    head_s      = mem_r[rd_ptr_r];
  end

  // Frame capture and unload bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r <= 128'd0;
      mask_r   <= 8'd0;
      sof_r    <= 1'b0;
    end else if ((state_r == WAIT) && done_rise_s) begin
      shadow_r <= adc_data;
      mask_r   <= ch_mask;
      sof_r    <= 1'b1;
    end else if (state_r == UNLOAD) begin
      mask_r <= mask_r & ~(8'd1 << cur_ch_s);
      sof_r  <= 1'b0;
    end else begin
      mask_r <= mask_r;
    end
  end

  // FIFO storage (no reset: contents are qualified by count_r).
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= entry_s;
  end

  // FIFO pointers, fill level and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      adc_start_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      adc_start_r <= (state_next_s == TRIG);
      busy_r      <= (state_next_s != IDLE);
      if (ovr_set_s)        overrun_r <= 1'b1;
      else if (overrun_clr) overrun_r <= 1'b0;
      else                  overrun_r <= overrun_r;
      if (push_s && last_s) frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  assign adc_start = adc_start_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign frame_cnt = frame_cnt_r;
  assign out_valid = out_valid_s;
  assign out_data  = out_valid_s ? head_s[15:0]  : 16'd0;
  assign out_ch    = out_valid_s ? head_s[18:16] : 3'd0;
  assign out_sof   = out_valid_s ? head_s[19]    : 1'b0;
endmodule

// File: tb/tb_ad7606_sched.sv
// Directed bench for ad7606_sched with a simple AD7606 driver model (PERIOD=250, FIFO_DEPTH=16).
// Also exercises the watchdog when built with AD7606_SCHED_TIMEOUT_EN.
module tb_ad7606_sched;
  logic         clk, rst_n, run, single, adc_start, adc_done, out_valid, out_ready;
  logic         out_sof, busy, overrun, overrun_clr, timeout_err;
  logic [7:0]   ch_mask;
  logic [127:0] adc_data;
  logic [15:0]  out_data, frame_cnt;
  logic [2:0]   out_ch;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int drv_cnt = 0;
  int done_hold = 0;
  bit drv_en = 1'b1;
  bit done_manual = 1'b0;
  int starts[$];
  logic [19:0] popped[$];

  ad7606_sched #(.CLK_FRE(1), .SAMPLE_FRE(4000), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .single(single), .ch_mask(ch_mask),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_sof(out_sof), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver model: done rises 20 cycles after adc_start and stays high for 2 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      drv_cnt   = 0;
      done_hold = 0;
    end else begin
      if (drv_cnt > 0) begin
        drv_cnt = drv_cnt - 1;
        if (drv_cnt == 0) done_hold = 2;
      end else if (done_hold > 0) begin
        done_hold = done_hold - 1;
      end
      if (adc_start && drv_en) drv_cnt = 20;
    end
    adc_done = (done_hold > 0) || done_manual;
  end

  // Monitor: record start cycles and every accepted FIFO word.
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (rst_n && adc_start) starts.push_back(cyc_n);
    if (rst_n && out_valid && out_ready) popped.push_back({out_sof, out_ch, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_single();
    single = 1'b1;
    cyc();
    single = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      cyc();
      n++;
    end
    check("idle_bound", 32'(busy), 32'd0);
    repeat (4) cyc();
  endtask

  function automatic logic [19:0] word_at(input int i);
    if (i < popped.size()) return popped[i];
    else return 20'hFFFFF;
  endfunction

  initial begin
    int bad;
    int n;
    logic [19:0] expw;
    rst_n = 1'b0; run = 1'b0; single = 1'b0; ch_mask = 8'h00; out_ready = 1'b1;
    overrun_clr = 1'b0;
    for (int i = 0; i < 8; i++) adc_data[16*i +: 16] = 16'h1000 + 16'(i);
    repeat (3) cyc();
    check("rst_outs", {15'd0, adc_start, out_valid, out_data, out_ch, out_sof, busy, overrun, timeout_err},
          32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // One-shot frame, channels 0 and 2.
    ch_mask = 8'h05;
    pulse_single();
    check("single_start", 32'(adc_start), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    cyc();
    check("start_one_cycle", 32'(adc_start), 32'd0);
    wait_idle(100);
    check("single_nwords", 32'(popped.size()), 32'd2);
    check("single_w0", 32'(word_at(0)), {12'd0, 1'b1, 3'd0, 16'h1000});
    check("single_w1", 32'(word_at(1)), {12'd0, 1'b0, 3'd2, 16'h1002});
    check("single_frames", 32'(frame_cnt), 32'd1);

    // Run mode for 3.5 periods, all channels.
    popped.delete(); starts.delete();
    ch_mask = 8'hFF;
    run = 1'b1;
    repeat (875) cyc();
    run = 1'b0;
    wait_idle(100);
    check("run_nstarts", 32'(starts.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      check("run_spacing", 32'((i < starts.size()) ? starts[i] - starts[i-1] : 0), 32'd250);
    check("run_nwords", 32'(popped.size()), 32'd32);
    bad = 0;
    for (int i = 0; i < popped.size(); i++) begin
      expw = {((i % 8) == 0) ? 1'b1 : 1'b0, 3'(i % 8), 16'h1000 + 16'(i % 8)};
      if (popped[i] !== expw) bad++;
    end
    check("run_words", 32'(bad), 32'd0);
    check("run_overrun", 32'(overrun), 32'd0);
    check("run_frames", 32'(frame_cnt), 32'd5);

    // Full FIFO: third frame is dropped.
    popped.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_single();
      wait_idle(100);
    end
    check("full_overrun", 32'(overrun), 32'd1);
    check("full_frames", 32'(frame_cnt), 32'd7);
    check("full_head", {12'd0, out_valid, out_sof, out_ch, out_data}, {12'd0, 1'b1, 1'b1, 3'd0, 16'h1000});
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    repeat (20) cyc();
    check("drain_nwords", 32'(popped.size()), 32'd16);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Single during WAIT is discarded and flagged.
    starts.delete();
    pulse_single();
    cyc();
    pulse_single();
    check("wait_single_ovr", 32'(overrun), 32'd1);
    wait_idle(100);
    check("wait_single_starts", 32'(starts.size()), 32'd1);
    check("wait_single_frames", 32'(frame_cnt), 32'd8);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;

    // Single coincident with the first run tick yields one frame.
    popped.delete(); starts.delete();
    ch_mask = 8'h80;
    run = 1'b1; single = 1'b1;
    cyc();
    run = 1'b0; single = 1'b0;
    wait_idle(100);
    check("coinc_starts", 32'(starts.size()), 32'd1);
    check("coinc_overrun", 32'(overrun), 32'd0);
    check("coinc_word", 32'(word_at(0)), {12'd0, 1'b1, 3'd7, 16'h1007});
    check("coinc_frames", 32'(frame_cnt), 32'd9);

    // Zero mask drops silently.
    popped.delete();
    ch_mask = 8'h00;
    pulse_single();
    wait_idle(100);
    check("zmask_words", 32'(popped.size()), 32'd0);
    check("zmask_state", {30'd0, overrun, frame_cnt == 16'd9}, 32'd1);

`ifdef AD7606_SCHED_TIMEOUT_EN
    drv_en = 1'b0;
    pulse_single();
    wait_idle(300);
    check("timeout_err", 32'(timeout_err), 32'd1);
    drv_en = 1'b1;
    pulse_single();
    check("timeout_restart", 32'(adc_start), 32'd1);
    wait_idle(100);
`else
    check("timeout_tied", 32'(timeout_err), 32'd0);
`endif

    // Reset in the middle of UNLOAD.
    ch_mask = 8'hFF;
    out_ready = 1'b0;
    pulse_single();
    n = 0;
    while (!out_valid && n < 100) begin
      cyc();
      n++;
    end
    check("unload_reached", {30'd0, out_valid, busy}, 32'd3);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_outs", {15'd0, adc_start, out_valid, out_data, out_ch, out_sof, busy, overrun, timeout_err},
          32'd0);
    check("mid_rst_frames", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();
    done_manual = 1'b1;
    repeat (2) cyc();
    done_manual = 1'b0;
    repeat (15) cyc();
    check("post_rst_nowrite", {30'd0, out_valid, busy}, 32'd0);
    check("post_rst_frames", 32'(frame_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
